// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: passive I2C sniffer for the iCE40 I2C pin-primitive stage.
// Synchronises and deglitches SDA/SCL, flags START / repeated START / STOP,
// and reports every completed byte together with its ACK bit.
// The bus is never driven from here.
module i2c_bus_monitor #(
  parameter int FILTER_LEN = 3
) (
  input  logic       ICE_CLK,
  input  logic       RST,
  input  logic       SDA_DIN,
  input  logic       SCL_DIN,
  output logic       START_PULSE,
  output logic       STOP_PULSE,
  output logic       BUS_BUSY,
  output logic       BYTE_VALID,
  output logic [7:0] BYTE_DATA,
  output logic       BYTE_ACK,
  output logic       BYTE_IS_ADDR,
  output logic       ERR
);

  localparam int CNT_W = (FILTER_LEN < 1) ? 1 : $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((FILTER_LEN < 1) ? 0 : FILTER_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_ACK
  } state_t;

  state_t state;

  logic sda_s1, sda_s2, scl_s1, scl_s2;
  logic sda_f, scl_f;
  logic sda_prev, scl_prev;
  logic [CNT_W-1:0] sda_cnt, scl_cnt;

  logic [3:0] bitcnt;
  logic [7:0] shreg;
  logic       first;
  logic       bit_pend;
  logic       bit_sample;

  logic scl_rise, scl_fall, start_det, stop_det;

  // Two-flop synchronisers; idle-high reset values keep the first cycles edge-free.
  always_ff @(posedge ICE_CLK) begin
    if (RST) begin
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
    end else begin
      sda_s1 <= SDA_DIN;
      sda_s2 <= sda_s1;
      scl_s1 <= SCL_DIN;
      scl_s2 <= scl_s1;
    end
  end

  // Deglitch filters: a line only flips after FILTER_LEN consecutive differing samples.
  always_ff @(posedge ICE_CLK) begin
    if (RST) begin
      sda_f   <= 1'b1;
      scl_f   <= 1'b1;
      sda_cnt <= '0;
      scl_cnt <= '0;
    end else begin
      if (sda_s2 != sda_f) begin
        if (sda_cnt == CNT_LAST) begin
          sda_f   <= sda_s2;
          sda_cnt <= '0;
        end else begin
          sda_cnt <= sda_cnt + 1'b1;
        end
      end else begin
        sda_cnt <= '0;
      end
      if (scl_s2 != scl_f) begin
        if (scl_cnt == CNT_LAST) begin
          scl_f   <= scl_s2;
          scl_cnt <= '0;
        end else begin
          scl_cnt <= scl_cnt + 1'b1;
        end
      end else begin
        scl_cnt <= '0;
      end
    end
  end

  // One-cycle-delayed filtered lines used for edge detection.
  always_ff @(posedge ICE_CLK) begin
    if (RST) begin
      sda_prev <= 1'b1;
      scl_prev <= 1'b1;
    end else begin
      sda_prev <= sda_f;
      scl_prev <= scl_f;
    end
  end

  // Bus conditions; a simultaneous SCL+SDA change is neither START nor STOP.
  always_comb begin
    scl_rise  = !scl_prev & scl_f;
    scl_fall  = scl_prev & !scl_f;
    start_det = sda_prev & !sda_f & scl_prev & scl_f;
    stop_det  = !sda_prev & sda_f & scl_prev & scl_f;
  end

  // Protocol FSM. A data bit is sampled on the SCL rise but only committed on the
  // following SCL fall: every START/STOP is preceded by an SCL rise, and that rise
  // must not count as a data bit of the byte the condition interrupts.
  always_ff @(posedge ICE_CLK) begin
    if (RST) begin
      state        <= S_IDLE;
      bitcnt       <= 4'd0;
      shreg        <= 8'h00;
      first        <= 1'b0;
      bit_pend     <= 1'b0;
      bit_sample   <= 1'b0;
      START_PULSE  <= 1'b0;
      STOP_PULSE   <= 1'b0;
      BUS_BUSY     <= 1'b0;
      BYTE_VALID   <= 1'b0;
      BYTE_DATA    <= 8'h00;
      BYTE_ACK     <= 1'b0;
      BYTE_IS_ADDR <= 1'b0;
      ERR          <= 1'b0;
    end else begin
      START_PULSE <= 1'b0;
      STOP_PULSE  <= 1'b0;
      BYTE_VALID  <= 1'b0;
      ERR         <= 1'b0;
      if (start_det) begin
        START_PULSE <= 1'b1;
        BUS_BUSY    <= 1'b1;
        ERR         <= (bitcnt != 4'd0);
        bitcnt      <= 4'd0;
        first       <= 1'b1;
        bit_pend    <= 1'b0;
        state       <= S_DATA;
      end else if (stop_det) begin
        STOP_PULSE <= 1'b1;
        BUS_BUSY   <= 1'b0;
        ERR        <= (bitcnt != 4'd0);
        bitcnt     <= 4'd0;
        bit_pend   <= 1'b0;
        state      <= S_IDLE;
      end else begin
        case (state)
          S_DATA: begin
            if (scl_rise) begin
              bit_sample <= sda_f;
              bit_pend   <= 1'b1;
            end else if (scl_fall && bit_pend) begin
              bit_pend <= 1'b0;
              shreg    <= {shreg[6:0], bit_sample};
              bitcnt   <= bitcnt + 4'd1;
              if (bitcnt == 4'd7) begin
                state <= S_ACK;
              end
            end
          end
          S_ACK: begin
            if (scl_rise) begin
              BYTE_VALID   <= 1'b1;
              BYTE_DATA    <= shreg;
              BYTE_ACK     <= sda_f;
              BYTE_IS_ADDR <= first;
              first        <= 1'b0;
              bitcnt       <= 4'd0;
              state        <= S_DATA;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// tb_i2c_bus_monitor: drives I2C transactions into i2c_bus_monitor and checks
// reported bytes against a scoreboard filled as each byte is driven.
module tb_i2c_bus_monitor;

  localparam int Q = 30;  // quarter SCL period in clocks: 100 kHz SCL at 12 MHz

  logic       ICE_CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SDA_DIN = 1'b1;
  logic       SCL_DIN = 1'b1;
  logic       START_PULSE, STOP_PULSE, BUS_BUSY, BYTE_VALID;
  logic [7:0] BYTE_DATA;
  logic       BYTE_ACK, BYTE_IS_ADDR, ERR;

  i2c_bus_monitor #(.FILTER_LEN(3)) dut (
    .ICE_CLK     (ICE_CLK),
    .RST         (RST),
    .SDA_DIN     (SDA_DIN),
    .SCL_DIN     (SCL_DIN),
    .START_PULSE (START_PULSE),
    .STOP_PULSE  (STOP_PULSE),
    .BUS_BUSY    (BUS_BUSY),
    .BYTE_VALID  (BYTE_VALID),
    .BYTE_DATA   (BYTE_DATA),
    .BYTE_ACK    (BYTE_ACK),
    .BYTE_IS_ADDR(BYTE_IS_ADDR),
    .ERR         (ERR)
  );

  always #5 ICE_CLK = ~ICE_CLK;

  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic       addr;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_e;

  int tests_run = 0;
  int tests_failed = 0;

  int start_cnt = 0, stop_cnt = 0, err_cnt = 0, err_stop_cnt = 0, byte_cnt = 0;
  int s_start, s_stop, s_err, s_err_stop, s_byte;
  logic prev_start = 1'b0, prev_stop = 1'b0, prev_err = 1'b0, prev_bv = 1'b0;
  logic first_byte = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: counts pulses, checks single-cycle width, pops the scoreboard per byte.
  always @(negedge ICE_CLK) begin
    if (START_PULSE) begin
      start_cnt++;
      checkOutput("start_width", 32'(prev_start), 0);
      checkOutput("busy_at_start", 32'(BUS_BUSY), 1);
    end
    if (STOP_PULSE) begin
      stop_cnt++;
      checkOutput("stop_width", 32'(prev_stop), 0);
      checkOutput("busy_at_stop", 32'(BUS_BUSY), 0);
      if (ERR) err_stop_cnt++;
    end
    if (ERR) begin
      err_cnt++;
      checkOutput("err_width", 32'(prev_err), 0);
    end
    if (BYTE_VALID) begin
      byte_cnt++;
      checkOutput("bv_width", 32'(prev_bv), 0);
      checkOutput("scoreboard_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        checkOutput("byte_data", 32'(BYTE_DATA), 32'(exp_e.data));
        checkOutput("byte_ack", 32'(BYTE_ACK), 32'(exp_e.ack));
        checkOutput("byte_is_addr", 32'(BYTE_IS_ADDR), 32'(exp_e.addr));
      end
    end
    prev_start = START_PULSE;
    prev_stop  = STOP_PULSE;
    prev_err   = ERR;
    prev_bv    = BYTE_VALID;
  end

  task automatic waitClocks(input int n);
    repeat (n) @(negedge ICE_CLK);
  endtask

  task automatic i2cStart();
    SDA_DIN = 1'b1;
    waitClocks(Q);
    SCL_DIN = 1'b1;
    waitClocks(Q);
    SDA_DIN = 1'b0;
    waitClocks(Q);
    SCL_DIN = 1'b0;
    waitClocks(Q);
    first_byte = 1'b1;
  endtask

  task automatic i2cStop();
    SDA_DIN = 1'b0;
    waitClocks(Q);
    SCL_DIN = 1'b1;
    waitClocks(Q);
    SDA_DIN = 1'b1;
    waitClocks(Q);
  endtask

  task automatic sendBit(input logic b);
    SDA_DIN = b;
    waitClocks(Q);
    SCL_DIN = 1'b1;
    waitClocks(2 * Q);
    SCL_DIN = 1'b0;
    waitClocks(Q);
  endtask

  task automatic sendByte(input logic [7:0] data, input logic ack);
    exp_t e;
    e.data = data;
    e.ack  = ack;
    e.addr = first_byte;
    exp_q.push_back(e);
    first_byte = 1'b0;
    for (int i = 7; i >= 0; i--) sendBit(data[i]);
    sendBit(ack);
  endtask

  task automatic takeSnapshot();
    s_start    = start_cnt;
    s_stop     = stop_cnt;
    s_err      = err_cnt;
    s_err_stop = err_stop_cnt;
    s_byte     = byte_cnt;
  endtask

  task automatic checkTest(input string t, input int e_start, input int e_stop,
                           input int e_err, input int e_err_stop, input int e_bytes);
    waitClocks(20);
    checkOutput({t, "_starts"}, 32'(start_cnt - s_start), 32'(e_start));
    checkOutput({t, "_stops"}, 32'(stop_cnt - s_stop), 32'(e_stop));
    checkOutput({t, "_errs"}, 32'(err_cnt - s_err), 32'(e_err));
    checkOutput({t, "_err_at_stop"}, 32'(err_stop_cnt - s_err_stop), 32'(e_err_stop));
    checkOutput({t, "_bytes"}, 32'(byte_cnt - s_byte), 32'(e_bytes));
    checkOutput({t, "_pending"}, 32'(exp_q.size()), 0);
    checkOutput({t, "_busy_end"}, 32'(BUS_BUSY), 0);
  endtask

  // Main sequence of directed transactions.
  initial begin
    waitClocks(4);
    checkOutput("rst_start", 32'(START_PULSE), 0);
    checkOutput("rst_stop", 32'(STOP_PULSE), 0);
    checkOutput("rst_busy", 32'(BUS_BUSY), 0);
    checkOutput("rst_bv", 32'(BYTE_VALID), 0);
    checkOutput("rst_data", 32'(BYTE_DATA), 0);
    checkOutput("rst_ack", 32'(BYTE_ACK), 0);
    checkOutput("rst_addr", 32'(BYTE_IS_ADDR), 0);
    checkOutput("rst_err", 32'(ERR), 0);
    RST = 1'b0;
    waitClocks(10);

    // Address + one data byte, both ACKed.
    takeSnapshot();
    i2cStart();
    checkOutput("t1_busy_mid", 32'(BUS_BUSY), 1);
    sendByte(8'hA0, 1'b0);
    sendByte(8'hA5, 1'b0);
    checkOutput("t1_busy_before_stop", 32'(BUS_BUSY), 1);
    i2cStop();
    checkTest("t1", 1, 1, 0, 0, 2);

    // SDA glitches with SCL high: 2 cycles filtered out, 3 cycles pass.
    takeSnapshot();
    SDA_DIN = 1'b0;
    waitClocks(2);
    SDA_DIN = 1'b1;
    waitClocks(20);
    checkOutput("t2_short_glitch_starts", 32'(start_cnt - s_start), 0);
    checkOutput("t2_short_glitch_busy", 32'(BUS_BUSY), 0);
    SDA_DIN = 1'b0;
    waitClocks(3);
    SDA_DIN = 1'b1;
    checkTest("t2", 1, 1, 0, 0, 0);

    // Repeated START between two address bytes, second NACKed.
    takeSnapshot();
    i2cStart();
    sendByte(8'hA0, 1'b0);
    i2cStart();
    sendByte(8'hA1, 1'b1);
    i2cStop();
    checkTest("t3", 2, 1, 0, 0, 2);

    // STOP after a partial byte: ERR with STOP, no byte.
    takeSnapshot();
    i2cStart();
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b1);
    i2cStop();
    checkTest("t4", 1, 1, 1, 1, 0);

    // All-ones byte with NACK.
    takeSnapshot();
    i2cStart();
    sendByte(8'hFF, 1'b1);
    i2cStop();
    checkTest("t5", 1, 1, 0, 0, 1);

    // Reset mid-byte, then clocks without START are ignored.
    i2cStart();
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    SDA_DIN = 1'b1;
    waitClocks(Q);
    RST = 1'b1;
    waitClocks(3);
    checkOutput("t6_rst_busy", 32'(BUS_BUSY), 0);
    checkOutput("t6_rst_data", 32'(BYTE_DATA), 0);
    checkOutput("t6_rst_ack", 32'(BYTE_ACK), 0);
    checkOutput("t6_rst_addr", 32'(BYTE_IS_ADDR), 0);
    RST = 1'b0;
    waitClocks(10);
    takeSnapshot();
    for (int i = 0; i < 9; i++) sendBit(i[0]);
    checkTest("t6a", 0, 0, 0, 0, 0);
    takeSnapshot();
    i2cStart();
    sendByte(8'h3C, 1'b0);
    i2cStop();
    checkTest("t6b", 1, 1, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
